writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- MEM/WB-side producer of the register-file write port: accepts one retiring instruction per cycle and selects ALU result or load data.
- Extracts and extends byte/half loads, resolves destination (rd vs rt), drives a single-cycle write strobe.
- Stalls upstream while waiting for load data; watchdog flags memory that never responds.

Parameters:
- MEM_TIMEOUT, 16, max cycles in WAIT_MEM before err_timeout; counter width = clog2(MEM_TIMEOUT+1).

Ports:
- clock  in  1  system clock; all state on posedge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  retiring instruction present
- in_ready  out  1  unit can accept this cycle
- in_rwe  in  1  instruction writes a register
- in_rdst  in  1  1: dest = in_rd, 0: dest = in_rt
- in_rd  in  5  rd index
- in_rt  in  5  rt index
- in_mem_to_reg  in  1  1: load, data from memory
- in_load_size  in  2  0 byte, 1 half, 2 word (3 treated as word)
- in_load_signed  in  1  sign-extend byte/half
- in_byte_off  in  2  address[1:0] of load
- in_alu_result  in  32  ALU result
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data word, big-endian lanes (offset 0 = bits 31:24)
- wb_we  out  1  register-file write enable
- wb_addr  out  5  register-file write index
- wb_data  out  32  register-file write data
- err_timeout  out  1  sticky load-timeout flag

Behaviour:
- All outputs registered on posedge. Register file samples them on the following negedge.
- Reset (resetn low, async): state IDLE; wb_we=0, wb_addr=0, wb_data=0, err_timeout=0; wait counter=0.
- in_ready = 1 in IDLE and WRITE, 0 in WAIT_MEM. Transfer occurs when in_valid & in_ready.
- States: IDLE, WAIT_MEM, WRITE.
- Transfer, non-load (in_mem_to_reg=0):
  - Next cycle wb_data = in_alu_result, wb_addr = resolved dest, wb_we = in_rwe & (dest != 0); state WRITE.
  - Latency 1. Back-to-back transfers give wb_we high every cycle.
- Transfer, load: dest and load controls latched; state WAIT_MEM; wb_we=0 next cycle.
- WAIT_MEM:
  - mem_rvalid is sampled only here; it is ignored in IDLE and WRITE.
  - On mem_rvalid: extract lane per in_byte_off. Half uses offset[1] only (offset[0] ignored). Word ignores offset.
  - Zero- or sign-extend to 32 bits; wb_we = latched rwe & (dest != 0) next cycle; state WRITE; counter cleared.
  - Without mem_rvalid the counter increments. When it reaches MEM_TIMEOUT: err_timeout=1, pending write dropped (no wb_we), state IDLE.
- WRITE: wb_we held exactly one cycle. Next state WRITE on a new non-load transfer, WAIT_MEM on a load transfer, else IDLE with wb_we=0.
- wb_addr/wb_data hold their last values when wb_we=0.
- Register 0 is never written (wb_we suppressed); the pipeline still advances normally.
- err_timeout clears only on reset.
- Reset asserted mid-WAIT_MEM discards the pending load; a later mem_rvalid is ignored.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined: adds outputs fwd_valid(1), fwd_addr(5), fwd_data(32), combinationally equal to the write about to be issued. That is, the non-load transfer value or the extended load value in the mem_rvalid cycle, before registering. Execute-stage bypass uses it.
  - fwd_valid = would-be wb_we next cycle.
  - fwd_valid is 0 during reset and on timeout.
- Undefined: ports absent; no extra logic.

Decomposition:
- Shared package / control header: load-size encodings (LS_BYTE=0, LS_HALF=1, LS_WORD=2), state encodings, REG_ZERO=0.
- Sub-module load_align: pure combinational lane select plus extension (rdata, size, signed, off -> 32-bit). Unit-tested separately.

Test Plan:
- ALU op: in_rwe=1, in_rdst=1, in_rd=5, alu=0x12345678 -> next cycle wb_we=1, wb_addr=5, wb_data=0x12345678; following cycle wb_we=0.
- Signed byte load: off=1, rdata=0x1180FF00, rt=9, rdst=0; mem_rvalid 3 cycles after transfer -> in_ready=0 for those 3 cycles; then wb_data=0xFFFFFF80, wb_addr=9.
- Unsigned half load, off=2, rdata=0xAAAA8001 -> wb_data=0x00008001. Word load, off=3 -> full word written.
- Dest 0: rdst=1, rd=0 -> wb_we stays 0. Next instruction still accepted and written in the following cycle.
- Timeout: load with no mem_rvalid for MEM_TIMEOUT=16 cycles -> err_timeout=1 and sticky, no write, in_ready=1 afterwards.
- Reset in WAIT_MEM: assert resetn=0 mid-wait, then mem_rvalid after release -> no write; all outputs 0.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared encodings for the writeback unit: load sizes, FSM states,
// the hard-wired zero register and the load extension helper.
package writeback_unit_pkg;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } state_t;

    function automatic logic [31:0] extend16(
        input logic [15:0] v,
        input logic        half,
        input logic        sgn
    );
        logic top;
        top = half ? v[15] : v[7];
        if (half)
            return {{16{sgn & top}}, v};
        return {{24{sgn & top}}, v[7:0]};
    endfunction

endpackage

// File: rtl/writeback_unit_load_align.sv
// Load lane select and extension; big-endian lanes, offset 0 = bits 31:24.
// Pure combinational.
module load_align
    import writeback_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[31:24];
        unique case (off)
            2'd0: lane_b = rdata[31:24];
            2'd1: lane_b = rdata[23:16];
            2'd2: lane_b = rdata[15:8];
            2'd3: lane_b = rdata[7:0];
            default: lane_b = rdata[31:24];
        endcase
    end

    // half loads only look at off[1]; an odd offset is treated as aligned
    assign lane_h = off[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        data = rdata;
        unique case (1'b1)
            (size == LS_BYTE): data = extend16({8'd0, lane_b}, 1'b0, sgn);
            (size == LS_HALF): data = extend16(lane_h, 1'b1, sgn);
            default:           data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port producer: ALU/load select, load wait with watchdog.
// Optional execute-stage bypass outputs under WB_FORWARD_EN.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_rwe,
    input  logic        in_rdst,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rt,
    input  logic        in_mem_to_reg,
    input  logic [1:0]  in_load_size,
    input  logic        in_load_signed,
    input  logic [1:0]  in_byte_off,
    input  logic [31:0] in_alu_result,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        err_timeout
`ifdef WB_FORWARD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] cnt_inc;
    logic          cnt_hit;

    logic        lat_rwe;
    logic [4:0]  lat_dest;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_off;
    logic        latch_en;

    logic        we_nx;
    logic [4:0]  addr_nx;
    logic [31:0] data_nx;
    logic        err_nx;

    logic        xfer;
    logic [4:0]  dest;
    logic [31:0] ld_data;

    assign in_ready = (state != ST_WAIT_MEM);
    assign xfer     = in_valid & in_ready;
    assign dest     = in_rdst ? in_rd : in_rt;
    assign cnt_inc  = cnt + 1'b1;
    assign cnt_hit  = (cnt_inc == CW'(MEM_TIMEOUT));

    load_align u_align (
        .rdata (mem_rdata),
        .size  (lat_size),
        .sgn   (lat_signed),
        .off   (lat_off),
        .data  (ld_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_WRITE: begin
                if (xfer)
                    state_nx = in_mem_to_reg ? ST_WAIT_MEM : ST_WRITE;
                else
                    state_nx = ST_IDLE;
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid)
                    state_nx = ST_WRITE;
                else if (cnt_hit)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        we_nx    = 1'b0;
        addr_nx  = wb_addr;
        data_nx  = wb_data;
        err_nx   = err_timeout;
        cnt_nx   = cnt;
        latch_en = 1'b0;
        unique case (state)
            ST_IDLE, ST_WRITE: begin
                if (xfer && !in_mem_to_reg) begin
                    we_nx = in_rwe & (dest != REG_ZERO);
                    if (we_nx) begin
                        addr_nx = dest;
                        data_nx = in_alu_result;
                    end
                end else if (xfer) begin
                    latch_en = 1'b1;
                    cnt_nx   = '0;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    we_nx  = lat_rwe & (lat_dest != REG_ZERO);
                    cnt_nx = '0;
                    if (we_nx) begin
                        addr_nx = lat_dest;
                        data_nx = ld_data;
                    end
                end else if (cnt_hit) begin
                    err_nx = 1'b1;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            err_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            wb_we       <= we_nx;
            wb_addr     <= addr_nx;
            wb_data     <= data_nx;
            err_timeout <= err_nx;
            cnt         <= cnt_nx;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lat_rwe    <= 1'b0;
            lat_dest   <= '0;
            lat_size   <= LS_BYTE;
            lat_signed <= 1'b0;
            lat_off    <= '0;
        end else if (latch_en) begin
            lat_rwe    <= in_rwe;
            lat_dest   <= dest;
            lat_size   <= in_load_size;
            lat_signed <= in_load_signed;
            lat_off    <= in_byte_off;
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid = we_nx & resetn;
    assign fwd_addr  = addr_nx;
    assign fwd_data  = data_nx;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed bench for writeback_unit against a
// transaction-level reference model.
module tb_writeback_unit;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_rwe;
    logic        in_rdst;
    logic [4:0]  in_rd;
    logic [4:0]  in_rt;
    logic        in_mem_to_reg;
    logic [1:0]  in_load_size;
    logic        in_load_signed;
    logic [1:0]  in_byte_off;
    logic [31:0] in_alu_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_timeout;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_busy;
    int          m_wait;
    bit          m_we_p;
    int          m_dest_p;
    int          m_size_p;
    bit          m_sgn_p;
    int          m_off_p;
    bit          e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit          e_err;

    always #5 clock = ~clock;

    writeback_unit #(.MEM_TIMEOUT(TO)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rwe         (in_rwe),
        .in_rdst        (in_rdst),
        .in_rd          (in_rd),
        .in_rt          (in_rt),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_load_size   (in_load_size),
        .in_load_signed (in_load_signed),
        .in_byte_off    (in_byte_off),
        .in_alu_result  (in_alu_result),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .err_timeout    (err_timeout)
`ifdef WB_FORWARD_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_val(logic [31:0] w, int size,
                                             bit sgn, int off);
        int v;
        if (size == 0) begin
            v = int'((w >> (8 * (3 - off))) & 32'hFF);
            if (sgn && v >= 128) v -= 256;
        end else if (size == 1) begin
            v = int'((w >> (16 * (1 - off / 2))) & 32'hFFFF);
            if (sgn && v >= 32768) v -= 65536;
        end else begin
            return w;
        end
        return 32'(v);
    endfunction

    // one clock cycle: inputs already driven; predict, clock, compare
    task automatic step();
        bit nwe;
        int d;
        nwe = 0;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        if (m_busy) begin
            if (mem_rvalid) begin
                m_busy = 0;
                nwe = m_we_p && m_dest_p != 0;
                if (nwe) begin
                    e_addr = 5'(m_dest_p);
                    e_data = load_val(mem_rdata, m_size_p, m_sgn_p, m_off_p);
                end
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    e_err  = 1;
                    m_busy = 0;
                end
            end
        end else if (in_valid) begin
            d = in_rdst ? int'(in_rd) : int'(in_rt);
            if (!in_mem_to_reg) begin
                nwe = in_rwe && d != 0;
                if (nwe) begin
                    e_addr = 5'(d);
                    e_data = in_alu_result;
                end
            end else begin
                m_busy   = 1;
                m_wait   = 0;
                m_we_p   = in_rwe;
                m_dest_p = d;
                m_size_p = int'(in_load_size);
                m_sgn_p  = in_load_signed;
                m_off_p  = int'(in_byte_off);
            end
        end
        e_we = nwe;
`ifdef WB_FORWARD_EN
        chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, nwe});
        if (nwe) begin
            chk("fwd_addr", {27'd0, fwd_addr}, {27'd0, e_addr});
            chk("fwd_data", fwd_data, e_data);
        end
`endif
        @(posedge clock);
        #1;
        chk("wb_we", {31'd0, wb_we}, {31'd0, e_we});
        chk("err_timeout", {31'd0, err_timeout}, {31'd0, e_err});
        if (e_we) begin
            chk("wb_addr", {27'd0, wb_addr}, {27'd0, e_addr});
            chk("wb_data", wb_data, e_data);
        end
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        #3;
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        chk("rst_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        m_busy = 0;
        m_wait = 0;
        e_we   = 0;
        e_addr = '0;
        e_data = '0;
        e_err  = 0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic set_alu(input bit rwe, input bit rdst, input int rd,
                           input int rt, input logic [31:0] alu);
        in_valid      = 1'b1;
        in_rwe        = rwe;
        in_rdst       = rdst;
        in_rd         = 5'(rd);
        in_rt         = 5'(rt);
        in_mem_to_reg = 1'b0;
        in_alu_result = alu;
        mem_rvalid    = 1'b0;
    endtask

    task automatic set_load(input bit rdst, input int rd, input int rt,
                            input int size, input bit sgn, input int off);
        in_valid       = 1'b1;
        in_rwe         = 1'b1;
        in_rdst        = rdst;
        in_rd          = 5'(rd);
        in_rt          = 5'(rt);
        in_mem_to_reg  = 1'b1;
        in_load_size   = 2'(size);
        in_load_signed = sgn;
        in_byte_off    = 2'(off);
        in_alu_result  = 32'hDEAD_BEEF;
        mem_rvalid     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mem_resp(input logic [31:0] w);
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = w;
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        in_rwe         = 0;
        in_rdst        = 0;
        in_rd          = 0;
        in_rt          = 0;
        in_mem_to_reg  = 0;
        in_load_size   = 0;
        in_load_signed = 0;
        in_byte_off    = 0;
        in_alu_result  = 0;
        mem_rdata      = 0;
        do_reset();

        // ALU op, then idle
        set_alu(1, 1, 5, 7, 32'h1234_5678);
        step();
        chk("alu_addr", {27'd0, wb_addr}, 32'd5);
        chk("alu_data", wb_data, 32'h1234_5678);
        idle_cycles(1);

        // signed byte, response after 3 wait cycles
        set_load(0, 3, 9, 0, 1, 1);
        step();
        idle_cycles(3);
        mem_resp(32'h1180_FF00);
        chk("sb_data", wb_data, 32'hFFFF_FF80);
        chk("sb_addr", {27'd0, wb_addr}, 32'd9);

        // unsigned half at offset 2, then word at offset 3
        set_load(1, 12, 0, 1, 0, 2);
        step();
        mem_resp(32'hAAAA_8001);
        chk("lhu_data", wb_data, 32'h0000_8001);
        set_load(1, 13, 0, 2, 1, 3);
        step();
        mem_resp(32'hCAFE_F00D);
        chk("lw_data", wb_data, 32'hCAFE_F00D);
        set_load(1, 14, 0, 3, 1, 1);
        step();
        mem_resp(32'h8765_4321);

        // dest 0 then back-to-back ALU ops
        set_alu(1, 1, 0, 4, 32'h0BAD_0BAD);
        step();
        set_alu(1, 0, 0, 6, 32'h0000_0066);
        step();
        set_alu(1, 1, 31, 0, 32'hFFFF_FFFF);
        step();
        idle_cycles(1);

        // timeout: no response for TO cycles
        set_load(1, 20, 0, 2, 0, 0);
        step();
        idle_cycles(TO + 2);
        chk("to_sticky", {31'd0, err_timeout}, 32'd1);
        set_alu(1, 1, 21, 0, 32'h0000_0021);
        step();

        // reset in WAIT_MEM drops the load
        do_reset();
        set_load(1, 22, 0, 2, 0, 0);
        step();
        idle_cycles(2);
        do_reset();
        mem_resp(32'h5555_AAAA);
        chk("rst_drop_data", wb_data, 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_rwe         = ($urandom_range(0, 7) != 0);
            in_rdst        = 1'($urandom);
            in_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            in_rt          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            in_mem_to_reg  = ($urandom_range(0, 2) == 0);
            in_load_size   = 2'($urandom);
            in_load_signed = 1'($urandom);
            in_byte_off    = 2'($urandom);
            in_alu_result  = $urandom;
            mem_rvalid     = ($urandom_range(0, 2) == 0);
            mem_rdata      = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
